ex_operand_stage: RTL and testbench

Registered operand stage directly upstream of the single-cycle ALU. Each accepted instruction supplies register values, an immediate and a 3-bit ALU opcode. The stage selects the B operand, snoops the writeback bus to forward fresh results, and presents `a`, `b` and `ctrl` to the ALU through a valid/ready handshake. A 2-entry skid buffer decouples decode from downstream stalls without a combinational ready path.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/operand_fwd.sv | 31 +++
 rtl/ex_operand_stage.sv | 131 +++++++++++++
 tb/tb_ex_operand_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes, default widths, and the operand-stage entry.
// Used by ex_operand_stage (forwarding enabled by defining EX_OPERAND_FWD_EN).
package cpu_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int CPU_RA_W  = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           ctrl;
    logic [CPU_RA_W-1:0]  rs_addr;
    logic [CPU_RA_W-1:0]  rt_addr;
    logic [CPU_WIDTH-1:0] rs_val;
    logic [CPU_WIDTH-1:0] rt_val;
    logic [CPU_WIDTH-1:0] imm;
    logic                 use_imm;
    logic [CPU_RA_W-1:0]  rd_addr;
    logic                 wr_en;
  } entry_t;

endpackage

// File: rtl/operand_fwd.sv
// Compare-and-replace of one entry's rs/rt values against the writeback bus.
// Active only when EX_OPERAND_FWD_EN is defined; otherwise a passthrough.
module operand_fwd
  import cpu_pkg::*;
(
  input  entry_t               e_i,
  input  logic                 fwd_valid,
  input  logic [CPU_RA_W-1:0]  fwd_addr,
  input  logic [CPU_WIDTH-1:0] fwd_data,
  output entry_t               e_o
);

`ifdef EX_OPERAND_FWD_EN
  logic hit;

  always_comb begin
    e_o = e_i;
    hit = fwd_valid && (fwd_addr != '0);
    if (hit && (e_i.rs_addr == fwd_addr))
      e_o.rs_val = fwd_data;
    if (hit && (e_i.rt_addr == fwd_addr))
      e_o.rt_val = fwd_data;
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_data};
  assign e_o = e_i;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// Registered ALU operand stage with 2-entry skid buffer and writeback snoop.
// Define EX_OPERAND_FWD_EN to enable forwarding from the fwd_* bus.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int RA_W  = CPU_RA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ctrl,
  input  logic [RA_W-1:0]  in_rs_addr,
  input  logic [RA_W-1:0]  in_rt_addr,
  input  logic [RA_W-1:0]  in_rd_addr,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic             in_wr_en,
  input  logic             flush,
  input  logic             fwd_valid,
  input  logic [RA_W-1:0]  fwd_addr,
  input  logic [WIDTH-1:0] fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_ctrl,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic             out_wr_en
);

  entry_t in_e, in_f;
  entry_t main_q, main_d, main_f;
  entry_t skid_q, skid_d, skid_f;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  always_comb begin
    in_e         = '0;
    in_e.valid   = in_valid;
    in_e.ctrl    = in_ctrl;
    in_e.rs_addr = in_rs_addr;
    in_e.rt_addr = in_rt_addr;
    in_e.rs_val  = in_rs_val;
    in_e.rt_val  = in_rt_val;
    in_e.imm     = in_imm;
    in_e.use_imm = in_use_imm;
    in_e.rd_addr = in_rd_addr;
    in_e.wr_en   = in_wr_en;
  end

  operand_fwd u_fwd_in (
    .e_i       (in_e),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .e_o       (in_f)
  );

  operand_fwd u_fwd_main (
    .e_i       (main_q),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .e_o       (main_f)
  );

  operand_fwd u_fwd_skid (
    .e_i       (skid_q),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .e_o       (skid_f)
  );

  assign accept = in_valid && in_ready_q;
  assign drain  = main_q.valid && out_ready;

  // in_ready_q always mirrors !skid_q.valid, so accept implies skid empty
  always_comb begin
    main_d = main_f;
    skid_d = skid_f;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else begin
      if (drain) begin
        if (skid_q.valid) begin
          main_d       = skid_f;
          skid_d.valid = 1'b0;
        end else begin
          main_d.valid = 1'b0;
        end
      end
      if (accept) begin
        if (!main_q.valid || drain) begin
          main_d       = in_f;
          main_d.valid = 1'b1;
        end else begin
          skid_d       = in_f;
          skid_d.valid = 1'b1;
        end
      end
    end
    in_ready_d = !skid_d.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_q.valid;
  assign out_a       = main_q.rs_val;
  assign out_b       = main_q.use_imm ? main_q.imm : main_q.rt_val;
  assign out_ctrl    = main_q.ctrl;
  assign out_rd_addr = main_q.rd_addr;
  assign out_wr_en   = main_q.wr_en;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus skid/flush/reset sequences.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_val, in_rt_val, in_imm;
  logic        in_use_imm, in_wr_en;
  logic        flush;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_rd_addr;
  logic        out_wr_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_rs_addr  (in_rs_addr),
    .in_rt_addr  (in_rt_addr),
    .in_rd_addr  (in_rd_addr),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_wr_en    (in_wr_en),
    .flush       (flush),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_ctrl    (out_ctrl),
    .out_rd_addr (out_rd_addr),
    .out_wr_en   (out_wr_en)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [4:0]  rs_a, rt_a, rd;
    logic [31:0] rs_v, rt_v, imm;
    logic        use_imm, wr;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [4:0] ra,
                       input logic [4:0] ta, input logic [31:0] rv,
                       input logic [31:0] tv, input logic [31:0] im,
                       input logic ui, input logic [4:0] rd,
                       input logic wr);
    in_valid   = 1'b1;
    in_ctrl    = c;
    in_rs_addr = ra;
    in_rt_addr = ta;
    in_rs_val  = rv;
    in_rt_val  = tv;
    in_imm     = im;
    in_use_imm = ui;
    in_rd_addr = rd;
    in_wr_en   = wr;
  endtask

  task automatic load_two();
    out_ready = 1'b0;
    drive(3'b001, 5'd1, 5'd2, 32'd11, 32'd12, 32'd0, 1'b0, 5'd3, 1'b1);
    tick();
    drive(3'b110, 5'd5, 5'd6, 32'd21, 32'd22, 32'd0, 1'b0, 5'd7, 1'b0);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'b100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0,
                1'b0, 1'b1, 32'd5, 32'd7};
    vecs[1] = '{3'b100, 5'd1, 5'd2, 5'd4, 32'd8, 32'd3, 32'hFFFF_FFFF,
                1'b1, 1'b1, 32'd8, 32'hFFFF_FFFF};
    vecs[2] = '{3'b111, 5'd9, 5'd10, 5'd31, 32'hDEAD_BEEF, 32'h1234_5678,
                32'h0000_00FF, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{3'b011, 5'd0, 5'd0, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF,
                32'h0000_0010, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0010};
    vecs[4] = '{3'b000, 5'd17, 5'd18, 5'd19, 32'hFFFF_0000, 32'h00FF_FF00,
                32'h5555_5555, 1'b0, 1'b1, 32'hFFFF_0000, 32'h00FF_FF00};
    vecs[5] = '{3'b010, 5'd20, 5'd21, 5'd22, 32'd0, 32'd1,
                32'hAAAA_AAAA, 1'b1, 1'b1, 32'd0, 32'hAAAA_AAAA};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_ctrl = '0; in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0;
    in_rs_val = '0; in_rt_val = '0; in_imm = '0;
    in_use_imm = 1'b0; in_wr_en = 1'b0;
    flush = 1'b0;
    fwd_valid = 1'b0; fwd_addr = '0; fwd_data = '0;
    out_ready = 1'b1;
    tick();
    tick();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_rd", 32'(out_rd_addr), 32'd0);
    chk("rst_wr_en", 32'(out_wr_en), 32'd0);

    rst_n = 1'b1;
    tick();

    // back-to-back vectors with out_ready=1, one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].ctrl, vecs[i].rs_a, vecs[i].rt_a, vecs[i].rs_v,
            vecs[i].rt_v, vecs[i].imm, vecs[i].use_imm, vecs[i].rd,
            vecs[i].wr);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_a", i), out_a, vecs[i].exp_a);
      chk($sformatf("v%0d_b", i), out_b, vecs[i].exp_b);
      chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wr", i), 32'(out_wr_en), 32'(vecs[i].wr));
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // skid fill, ignored input while full, ordered drain
    out_ready = 1'b0;
    drive(3'b001, 5'd1, 5'd2, 32'd11, 32'd12, 32'd0, 1'b0, 5'd3, 1'b1);
    tick();
    chk("skA_rdy", 32'(in_ready), 32'd1);
    chk("skA_a", out_a, 32'd11);
    drive(3'b110, 5'd5, 5'd6, 32'd21, 32'd22, 32'd0, 1'b0, 5'd7, 1'b0);
    tick();
    chk("skB_rdy", 32'(in_ready), 32'd0);
    chk("skB_hold_a", out_a, 32'd11);
    chk("skB_hold_ctrl", 32'(out_ctrl), 32'b001);
    drive(3'b100, 5'd8, 5'd9, 32'd31, 32'd32, 32'd0, 1'b0, 5'd10, 1'b1);
    tick();
    chk("full_ign_a", out_a, 32'd11);
    chk("full_ign_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("dr_B_valid", 32'(out_valid), 32'd1);
    chk("dr_B_a", out_a, 32'd21);
    chk("dr_B_b", out_b, 32'd22);
    chk("dr_B_ctrl", 32'(out_ctrl), 32'b110);
    chk("dr_B_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("dr_done", 32'(out_valid), 32'd0);

    // flush with both entries full and input present
    load_two();
    chk("fl_pre_rdy", 32'(in_ready), 32'd0);
    drive(3'b100, 5'd8, 5'd9, 32'd31, 32'd32, 32'd0, 1'b0, 5'd10, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("fl_valid2", 32'(out_valid), 32'd0);
    tick();
    chk("fl_valid3", 32'(out_valid), 32'd0);

    // flush with skid empty: same-cycle accepted input is discarded
    drive(3'b100, 5'd8, 5'd9, 32'd31, 32'd32, 32'd0, 1'b0, 5'd10, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_in_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fl_in_valid2", 32'(out_valid), 32'd0);

    // forwarding into a stalled main entry
    out_ready = 1'b0;
    drive(3'b100, 5'd4, 5'd6, 32'd40, 32'd60, 32'd0, 1'b0, 5'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fw_pre_a", out_a, 32'd40);
    fwd_valid = 1'b1; fwd_addr = 5'd4; fwd_data = 32'd99;
    tick();
    fwd_valid = 1'b0;
`ifdef EX_OPERAND_FWD_EN
    chk("fw_a", out_a, 32'd99);
`else
    chk("fw_off_a", out_a, 32'd40);
`endif
    chk("fw_valid", 32'(out_valid), 32'd1);
    fwd_valid = 1'b1; fwd_addr = 5'd0; fwd_data = 32'd55;
    tick();
    fwd_valid = 1'b0;
`ifdef EX_OPERAND_FWD_EN
    chk("fw_zero_a", out_a, 32'd99);
`else
    chk("fw_zero_a", out_a, 32'd40);
`endif
    chk("fw_b", out_b, 32'd60);
    out_ready = 1'b1;
    tick();

    // asynchronous reset mid-stream
    load_two();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_rdy", 32'(in_ready), 32'd1);
    chk("ar_a", out_a, 32'd0);
    chk("ar_b", out_b, 32'd0);
    chk("ar_ctrl", 32'(out_ctrl), 32'd0);
    chk("ar_rd", 32'(out_rd_addr), 32'd0);
    chk("ar_wr", 32'(out_wr_en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
